// File: rtl/rns107_reverse_conv_if.sv
// Handshake bus for the (107,128) residue-to-binary converter: residue pair in, reconstructed value out.
interface rns107_reverse_conv_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  r107;
    logic [6:0]  r128;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] x_out;
    logic        err;

    modport master (
        output in_valid, r107, r128, out_ready,
        input  in_ready, out_valid, x_out, err
    );

    modport slave (
        input  in_valid, r107, r128, out_ready,
        output in_ready, out_valid, x_out, err
    );
endinterface

// File: rtl/rns107_reverse_conv.sv
// Reverse converter for moduli {107, 128}: X = r128 + 128*k, k = ((r107 - r128) * 51) mod 107,
// with the multiply by 51 done serially in Horner form, one constant bit per MULT cycle.
module rns107_reverse_conv (
    input  logic                  clk,
    input  logic                  rst_n,
    rns107_reverse_conv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, DIFF, MULT, DONE} state_t;

    // 51 = 6'b110011, walked from bit 5 down to bit 0
    localparam logic [7:0] K51 = 8'b0011_0011;

    state_t      state_r, state_s;
    logic [6:0]  r107_r, r107_s;
    logic [6:0]  r128_r, r128_s;
    logic [6:0]  d_r, d_s;
    logic [6:0]  acc_r, acc_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [13:0] x_out_r, x_out_s;
    logic        err_r, err_s;
    logic        in_ready_r;
    logic        out_valid_r;

    logic [6:0]  r128m_s;
    logic [6:0]  diff_s;
    logic [7:0]  dbl_raw_s;
    logic [6:0]  dbl_s;
    logic [7:0]  sum_raw_s;
    logic [6:0]  step_s;

    // Datapath arithmetic and next-state logic
    always_comb begin
        state_s = state_r;
        r107_s  = r107_r;
        r128_s  = r128_r;
        d_s     = d_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        x_out_s = x_out_r;
        err_s   = err_r;

        if (r128_r >= 7'd107) begin
            r128m_s = r128_r - 7'd107;
        end else begin
            r128m_s = r128_r;
        end

        // Negative branch wraps mod 128 but the true result lies in 1..106, so 7 bits suffice
        if (r107_r >= r128m_s) begin
            diff_s = r107_r - r128m_s;
        end else begin
            diff_s = r107_r + 7'd107 - r128m_s;
        end

        dbl_raw_s = {acc_r, 1'b0};
        if (dbl_raw_s >= 8'd107) begin
            dbl_s = 7'(dbl_raw_s - 8'd107);
        end else begin
            dbl_s = dbl_raw_s[6:0];
        end

        sum_raw_s = {1'b0, dbl_s} + {1'b0, d_r};
        if (K51[cnt_r] == 1'b1) begin
            if (sum_raw_s >= 8'd107) begin
                step_s = 7'(sum_raw_s - 8'd107);
            end else begin
                step_s = sum_raw_s[6:0];
            end
        end else begin
            step_s = dbl_s;
        end

        case (state_r)
            IDLE: begin
                if (bus.in_valid == 1'b1) begin
                    r107_s  = bus.r107;
                    r128_s  = bus.r128;
                    state_s = DIFF;
                end else begin
                    state_s = IDLE;
                end
            end
            DIFF: begin
                if (r107_r >= 7'd107) begin
                    err_s   = 1'b1;
                    x_out_s = 14'd0;
                    state_s = DONE;
                end else begin
                    d_s     = diff_s;
                    acc_s   = 7'd0;
                    cnt_s   = 3'd5;
                    state_s = MULT;
                end
            end
            MULT: begin
                acc_s = step_s;
                if (cnt_r == 3'd0) begin
                    x_out_s = {step_s, r128_r};
                    err_s   = 1'b0;
                    state_s = DONE;
                end else begin
                    cnt_s   = cnt_r - 3'd1;
                    state_s = MULT;
                end
            end
            DONE: begin
                if (bus.out_ready == 1'b1) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            r107_r      <= 7'd0;
            r128_r      <= 7'd0;
            d_r         <= 7'd0;
            acc_r       <= 7'd0;
            cnt_r       <= 3'd0;
            x_out_r     <= 14'd0;
            err_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            r107_r      <= r107_s;
            r128_r      <= r128_s;
            d_r         <= d_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            x_out_r     <= x_out_s;
            err_r       <= err_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.x_out     = x_out_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_rns107_reverse_conv.sv
// Scoreboard bench for rns107_reverse_conv: expected {err, x} queued at drive time, popped on out_valid.
module tb_rns107_reverse_conv;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [14:0] exp_q[$];

    rns107_reverse_conv_if bus();

    rns107_reverse_conv dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // One full conversion with out_ready held high; latency counts the acceptance edge as edge 1.
    task automatic run_conv(input logic [6:0] a, input logic [6:0] b, input logic [14:0] expv,
                            input int exp_lat, input string name);
        int lat;
        bit got;
        logic [14:0] e;
        @(negedge clk);
        bus.r107 = a;
        bus.r128 = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_idle: got=%b exp=1", name, bus.in_ready);
        end
        exp_q.push_back(expv);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.r107 = 7'($urandom_range(0, 127));
        bus.r128 = 7'($urandom_range(0, 127));
        got = 1'b0;
        while (!got && lat < 20) begin
            if (bus.out_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no out_valid after %0d edges", name, lat);
        end else begin
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got=%0d exp=%0d", name, lat, exp_lat);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard: unexpected output", name);
            end else begin
                e = exp_q.pop_front();
                if ({bus.err, bus.x_out} !== e) begin
                    errors++;
                    $display("FAIL %s result: got err=%b x=%0d exp err=%b x=%0d",
                             name, bus.err, bus.x_out, e[14], e[13:0]);
                end
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s return_idle: got in_ready=%b out_valid=%b exp 1/0",
                         name, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.r107 = 7'd37;
        bus.r128 = 7'd104;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.x_out !== 14'd0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b x=%0d err=%b exp 1/0/0/0",
                     bus.in_ready, bus.out_valid, bus.x_out, bus.err);
        end
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_conv(7'd0,   7'd0,   {1'b0, 14'd0},     8, "zero");
        run_conv(7'd37,  7'd104, {1'b0, 14'd1000},  8, "x1000");
        run_conv(7'd93,  7'd72,  {1'b0, 14'd200},   8, "x200");
        run_conv(7'd106, 7'd127, {1'b0, 14'd13695}, 8, "x_top");
    endtask

    task automatic test_error();
        run_conv(7'd110, 7'd5,   {1'b1, 14'd0},    2, "err110");
        run_conv(7'd107, 7'd0,   {1'b1, 14'd0},    2, "err107");
        run_conv(7'd37,  7'd104, {1'b0, 14'd1000}, 8, "err_clear");
    endtask

    task automatic test_backpressure();
        int n;
        logic [14:0] e;
        @(negedge clk);
        bus.r107 = 7'd93;
        bus.r128 = 7'd72;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        exp_q.push_back({1'b0, 14'd200});
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_timeout: no out_valid");
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.r107 = 7'd37;
            bus.r128 = 7'd104;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.x_out !== 14'd200 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got out_valid=%b x=%0d in_ready=%b exp 1/200/0",
                         i, bus.out_valid, bus.x_out, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bp_scoreboard: queue empty");
        end else begin
            e = exp_q.pop_front();
            if ({bus.err, bus.x_out} !== e) begin
                errors++;
                $display("FAIL bp_result: got x=%0d exp=%0d", bus.x_out, e[13:0]);
            end
        end
        bus.out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL bp_dropped: got %0d extra out_valid cycles exp 0", n);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        @(negedge clk);
        bus.r107 = 7'd37;
        bus.r128 = 7'd104;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.x_out !== 14'd0) begin
            errors++;
            $display("FAIL abort_reset: got in_ready=%b out_valid=%b x=%0d exp 1/0/0",
                     bus.in_ready, bus.out_valid, bus.x_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL abort_no_output: got %0d out_valid cycles exp 0", n);
        end
        run_conv(7'd37, 7'd104, {1'b0, 14'd1000}, 8, "after_abort");
    endtask

    task automatic test_back_to_back();
        logic [6:0]  ra[4];
        logic [6:0]  rb[4];
        logic [14:0] ex[4];
        logic [14:0] e;
        int idx, got, cyc, last_acc;
        ra[0] = 7'd0;   rb[0] = 7'd0;   ex[0] = {1'b0, 14'd0};
        ra[1] = 7'd37;  rb[1] = 7'd104; ex[1] = {1'b0, 14'd1000};
        ra[2] = 7'd93;  rb[2] = 7'd72;  ex[2] = {1'b0, 14'd200};
        ra[3] = 7'd106; rb[3] = 7'd127; ex[3] = {1'b0, 14'd13695};
        idx = 0; got = 0; cyc = 0; last_acc = -1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.r107 = ra[0];
        bus.r128 = rb[0];
        bus.in_valid = 1'b1;
        while (got < 4 && cyc < 80) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_scoreboard: unexpected output x=%0d", bus.x_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.err, bus.x_out} !== e) begin
                        errors++;
                        $display("FAIL b2b_result%0d: got x=%0d exp=%0d", got, bus.x_out, e[13:0]);
                    end
                end
                got++;
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                exp_q.push_back(ex[idx]);
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 9) begin
                        errors++;
                        $display("FAIL b2b_interval: got=%0d exp=9", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                idx++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (idx < 4) begin
                bus.r107 = ra[idx];
                bus.r128 = rb[idx];
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (got != 4 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d results exp 4, %0d left queued", got, exp_q.size());
        end
    endtask

    task automatic test_sweep();
        int xs[$];
        int x;
        xs = '{0, 1, 106, 107, 127, 128, 13567, 13695};
        for (int i = 0; i < 2500; i++) xs.push_back(int'($urandom_range(0, 13695)));
        foreach (xs[i]) begin
            x = xs[i];
            run_conv(7'(x % 107), 7'(x % 128), {1'b0, 14'(x)}, 8, "sweep");
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.r107 = 7'd0;
        bus.r128 = 7'd0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_directed();
        test_error();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rns107_reverse_conv.md
RNS107_REVERSE_CONV -- requirements
Module: rns107_reverse_conv

Interface
REQ-001 SHALL have no parameters; moduli are fixed: m1 = 107, m2 = 128, dynamic range M = 13696.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: the residue pair on r107/r128 is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a pair.
REQ-006 SHALL have port r107, input, 7 bits: residue X mod 107, legal range 0..106.
REQ-007 SHALL have port r128, input, 7 bits: residue X mod 128, range 0..127.
REQ-008 SHALL have port out_valid, output, 1 bit: x_out and err are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port x_out, output, 14 bits: reconstructed X, range 0..13695.
REQ-011 SHALL have port err, output, 1 bit: the input r107 was 107 or greater (illegal residue).

Function
REQ-012 SHALL compute X = r128 + 128*k, with k = ((r107 - r128) * 51) mod 107; 51 is the inverse of 128 mod 107 (128 mod 107 = 21, and 21*51 = 1071 = 10*107 + 1).
REQ-013 SHALL implement a four-state FSM: IDLE, DIFF, MULT, DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE.
REQ-015 SHALL accept a pair on a rising edge with in_valid && in_ready, register r107 and r128, and enter DIFF.
REQ-016 DIFF (1 cycle) SHALL form r128m = r128 - 107 if r128 >= 107, else r128.
REQ-017 DIFF SHALL form d = r107 - r128m, plus 107 if the result is negative; d is 7 bits, 0..106.
REQ-018 DIFF SHALL clear acc to 0, load the bit counter with 5, and enter MULT.
REQ-019 MULT SHALL process the constant 51 = 6'b110011 in Horner form, MSB first, one bit per cycle, for exactly 6 cycles.
REQ-020 Each MULT cycle SHALL compute t = 2*acc, subtract 107 if t >= 107, then if the current constant bit is 1 add d and subtract 107 if the sum is 107 or more.
REQ-021 acc SHALL stay in 0..106 after every MULT step, using at most 8-bit intermediates.
REQ-022 MULT SHALL leave for DONE after the bit-0 step; x_out = {acc[6:0], r128_reg} is valid at 14 bits with no further add, since 128*k + r128 equals concatenation.
REQ-023 Latency SHALL be 8 rising edges from the acceptance edge until out_valid is high (1 DIFF + 6 MULT + 1 DONE entry); throughput SHALL be one conversion per 9 cycles minimum.
REQ-024 If r107 >= 107 at acceptance, DIFF SHALL go directly to DONE with err = 1 and x_out = 0, so out_valid is high 2 edges after acceptance.
REQ-025 DONE SHALL hold out_valid = 1 with x_out and err stable until an edge with out_ready = 1, then go to IDLE; in_ready is high the following cycle.
REQ-026 SHALL drive out_valid = 1 only in DONE; x_out and err hold their last values outside DONE.
REQ-027 in_valid and input data while in_ready = 0 SHALL be ignored; the block SHALL NOT queue a second request.
REQ-028 err SHALL be 0 for every legal input.

Reset
REQ-029 While rst_n = 0, the block SHALL be asynchronously in IDLE with in_ready = 1, out_valid = 0, x_out = 0, err = 0, acc = 0, and counter = 0.
REQ-030 Reset asserted in DIFF, MULT or DONE SHALL abort the conversion with no output produced; the first cycle after release is IDLE.

Verification
REQ-031 (r107, r128) = (0, 0) SHALL give x_out = 0 and err = 0, with out_valid at acceptance + 8 edges.
REQ-032 (37, 104) SHALL give x_out = 1000 (d = 40, k = 7); (93, 72) SHALL give x_out = 200 (d = 21, k = 1).
REQ-033 (106, 127) SHALL give x_out = 13695, the top of the range, exercising the r128 >= 107 correction.
REQ-034 (110, 5) SHALL give err = 1 and x_out = 0, with out_valid at acceptance + 2 edges.
REQ-035 out_ready held at 0 for 5 cycles in DONE SHALL leave out_valid, x_out and in_ready = 0 stable; in_valid pulses in that window SHALL be dropped.
REQ-036 rst_n pulsed low in the 4th MULT cycle SHALL produce no out_valid; a following (37, 104) request SHALL give 1000.
REQ-037 A random sweep of all 13696 X values SHALL give exact round-trip reconstruction, err = 0 and fixed latency for each.
